uart_parity_unit: RTL
=====================

// Module: uart_parity_unit
// PURPOSE
//  Parity generator/checker for the UART datapath. It serves the transmitter (parallel word in,
//  parity bit out) and the receiver (serial bit accumulation, then received-parity check).
//  Data length (5..MAX_WIDTH) and parity mode (none/even/odd/mark/space) are set per frame.
//  A saturating error counter is included.
// PARAMETERS
//  MAX_WIDTH  9  widest supported data word; data bus width
//  CNT_W      8  width of the saturating parity-error counter
// PORTS
//  clk          in   1          system clock, rising edge
//  rst          in   1          asynchronous reset, active-high
//  mode         in   3          000 none, 001 even, 010 odd, 011 mark, 100 space, 101-111 = none
//  data_len     in   4          bits per frame; <5 clamps to 5, >MAX_WIDTH clamps to MAX_WIDTH
//  load         in   1          parallel request: compute parity of data
//  data         in   MAX_WIDTH  parallel word, LSB first; bits >= data_len ignored
//  ser_start    in   1          begin serial accumulation of a frame
//  ser_valid    in   1          ser_bit is valid this cycle
//  ser_bit      in   1          serial data bit or received parity bit
//  ser_abort    in   1          drop the current serial frame
//  chk_en       in   1          sampled with ser_start: 1 = receive/check, 0 = generate only
//  clr_err      in   1          clear err_count
//  p_out        out  1          computed parity bit
//  p_valid      out  1          one-cycle strobe: p_out is valid
//  par_err      out  1          one-cycle strobe: received parity mismatch
//  err_count    out  CNT_W      saturating count of par_err strobes
//  busy         out  1          1 whenever state != IDLE
// BEHAVIOUR
//  Reset: state IDLE; p_out=0, p_valid=0, par_err=0, err_count=0, busy=0; internal acc/cnt=0.
//  Config: mode, data_len (after clamping) and chk_en are latched on an accepted load or ser_start.
//   They are held for the whole frame, so mid-frame input changes are ignored.
//  Parity function f(x), where x = XOR of the bits counted for the frame:
//   even: p = x; odd: p = ~x; mark: p = 1; space: p = 0; none: p = 0.
//  FSM states: IDLE, ACC, PCHK.
//  Parallel path (IDLE only):
//   load=1 at cycle N -> p_out = f(^(data & mask(data_len))) and p_valid=1 at N+1. State stays IDLE.
//   load in ACC/PCHK is ignored.
//  Serial path:
//   IDLE & ser_start -> ACC; acc=0, cnt=0.
//   ACC & ser_valid -> acc ^= ser_bit, cnt++.
//   On the data_len-th bit:
//    chk_en=0 or mode=none -> p_out = f(acc^bit) with p_valid=1 next cycle, then IDLE.
//    chk_en=1 and mode!=none -> PCHK; p_out = f(acc^bit) with p_valid=1 next cycle.
//   PCHK & ser_valid -> ser_bit is the received parity.
//    If ser_bit != p_out: par_err=1 next cycle, and err_count increments if below 2^CNT_W-1.
//    Then IDLE.
//  Boundary rules:
//   - load and ser_start together in IDLE: ser_start wins; load is dropped, no p_valid.
//   - ser_start in ACC/PCHK is ignored.
//   - ser_abort in ACC/PCHK: IDLE next cycle, no p_valid/par_err. It has priority over ser_valid.
//     In IDLE it has no effect.
//   - clr_err together with an increment: clear wins, err_count=0.
//   - err_count saturates at all-ones and never wraps.
//   - rst asserted mid-frame: immediate return to reset values; the frame is lost.
//   - p_out holds its last value between strobes. p_valid and par_err are never high more than
//     one cycle per event.
//  Latency: parallel = 1 cycle. Serial = 1 cycle after the last data bit (p_valid) or after the
//  parity bit (par_err).
// TESTING
//  1. mode=even, len=8, load data=9'h0A5 -> next cycle p_valid=1, p_out=0; mode=odd -> p_out=1.
//  2. mode=even, len=7, load data=9'h180 -> bits 7,8 masked, p_out=0. Then len=9 -> p_out=0;
//     len=3 clamps to 5.
//  3. chk_en=1, mode=even, len=8, serial 0x53 LSB-first -> p_valid with p_out=0.
//     Received parity 1 -> par_err pulse, err_count=1. Received 0 -> no par_err.
//  4. CNT_W=2: force 5 mismatches -> err_count sticks at 3. clr_err on an increment cycle -> 0.
//  5. ser_abort after 4 bits -> IDLE, no strobes. Next frame correct. rst mid-ACC -> all outputs 0.
//  6. load+ser_start same cycle -> serial frame runs, no parallel p_valid. mark/space -> p_out 1/0.

Source files
------------

// File: rtl/uart_parity_unit_if.sv
// ----------------------------------------------------------------------------
// uart_parity_unit_if
//   Bundles the configuration, parallel, serial and status signals of the
//   UART parity generator/checker so they can be passed as a single port.
//
//   master : the UART datapath side (drives requests, observes results)
//   slave  : the parity unit itself
//
//   Signals
//     mode       3          parity mode: 000 none, 001 even, 010 odd,
//                           011 mark, 100 space, 101-111 none
//     data_len   4          bits per frame, clamped to 5..MAX_WIDTH
//     load       1          parallel request
//     data       MAX_WIDTH  parallel word, LSB first
//     ser_start  1          begin serial frame
//     ser_valid  1          ser_bit valid this cycle
//     ser_bit    1          serial data bit or received parity bit
//     ser_abort  1          drop the current serial frame
//     chk_en     1          1 = receive/check, 0 = generate only
//     clr_err    1          clear err_count
//     p_out      1          computed parity bit (held between strobes)
//     p_valid    1          one-cycle strobe: p_out valid
//     par_err    1          one-cycle strobe: received parity mismatch
//     err_count  CNT_W      saturating count of par_err strobes
//     busy       1          unit is inside a serial frame
// ----------------------------------------------------------------------------
interface uart_parity_unit_if #(
  parameter int MAX_WIDTH = 9,
  parameter int CNT_W     = 8
);
  logic [2:0]           mode;
  logic [3:0]           data_len;
  logic                 load;
  logic [MAX_WIDTH-1:0] data;
  logic                 ser_start;
  logic                 ser_valid;
  logic                 ser_bit;
  logic                 ser_abort;
  logic                 chk_en;
  logic                 clr_err;
  logic                 p_out;
  logic                 p_valid;
  logic                 par_err;
  logic [CNT_W-1:0]     err_count;
  logic                 busy;

  modport master (
    output mode, data_len, load, data, ser_start, ser_valid, ser_bit,
           ser_abort, chk_en, clr_err,
    input  p_out, p_valid, par_err, err_count, busy
  );

  modport slave (
    input  mode, data_len, load, data, ser_start, ser_valid, ser_bit,
           ser_abort, chk_en, clr_err,
    output p_out, p_valid, par_err, err_count, busy
  );
endinterface

// File: rtl/uart_parity_unit.sv
// ----------------------------------------------------------------------------
// uart_parity_unit
//   Parity generator/checker for the UART datapath.
//   - Parallel path: a word presented with load yields its parity one cycle
//     later (p_out + p_valid strobe).
//   - Serial path: bits are accumulated after ser_start; after data_len bits
//     the parity is strobed out, and in check mode the next serial bit is
//     compared against it (par_err strobe + saturating err_count).
//   Mode, data length and chk_en are captured at the start of each request
//   and held for the whole frame.
//
//   Ports
//     clk   in  system clock, rising edge
//     rst   in  asynchronous reset, active-high
//     bus   uart_parity_unit_if.slave (see interface for signal list)
// ----------------------------------------------------------------------------
module uart_parity_unit #(
  parameter int MAX_WIDTH = 9,
  parameter int CNT_W     = 8
) (
  input  logic                clk,
  input  logic                rst,
  uart_parity_unit_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    PCHK = 2'd2
  } state_t;

  localparam logic [3:0] MIN_LEN = 4'd5;
  localparam logic [3:0] MAX_LEN = 4'(MAX_WIDTH);

  state_t               state_q, state_d;

  // Per-frame configuration, captured when a request is accepted
  logic [2:0]           mode_q;
  logic [3:0]           len_q;
  logic                 chk_q;

  // Serial accumulator: running XOR and number of bits taken so far
  logic                 acc_q;
  logic [3:0]           cnt_q;

  logic                 p_out_q;
  logic                 p_valid_q;
  logic                 par_err_q;
  logic [CNT_W-1:0]     err_cnt_q;

  logic [3:0]           len_in;
  logic [MAX_WIDTH-1:0] mask;
  logic                 cfg_latch;
  logic                 acc_clr;
  logic                 acc_step;
  logic                 par_fire;
  logic                 par_val;
  logic                 err_fire;

  // Map the XOR of the frame bits onto the parity bit for a given mode.
  // Codes 101..111 fall into the default branch and behave as "none".
  function automatic logic par_f(input logic [2:0] m, input logic x);
    case (m)
      3'b001:  par_f = x;
      3'b010:  par_f = ~x;
      3'b011:  par_f = 1'b1;
      default: par_f = 1'b0;
    endcase
  endfunction

  function automatic logic has_parity(input logic [2:0] m);
    has_parity = (m >= 3'b001) && (m <= 3'b100);
  endfunction

  // Clamp the requested length and build the bit mask for the parallel path
  always_comb begin
    // NOTE: every variable written in always_comb gets a default first so no
    // path can leave it unassigned, which would otherwise infer a latch.
    len_in = bus.data_len;
    if (bus.data_len < MIN_LEN)      len_in = MIN_LEN;
    else if (bus.data_len > MAX_LEN) len_in = MAX_LEN;

    mask = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      mask[i] = (i < int'(len_in));
    end
  end

  // Next-state and control decode
  always_comb begin
    state_d   = state_q;
    cfg_latch = 1'b0;
    acc_clr   = 1'b0;
    acc_step  = 1'b0;
    par_fire  = 1'b0;
    par_val   = p_out_q;
    err_fire  = 1'b0;

    case (state_q)
      IDLE: begin
        // ser_start has priority; a simultaneous load is dropped
        if (bus.ser_start) begin
          state_d   = ACC;
          cfg_latch = 1'b1;
          acc_clr   = 1'b1;
        end else if (bus.load) begin
          cfg_latch = 1'b1;
          par_fire  = 1'b1;
          par_val   = par_f(bus.mode, ^(bus.data & mask));
        end
      end

      ACC: begin
        if (bus.ser_abort) begin
          state_d = IDLE;
        end else if (bus.ser_valid) begin
          acc_step = 1'b1;
          if (cnt_q + 4'd1 == len_q) begin
            par_fire = 1'b1;
            par_val  = par_f(mode_q, acc_q ^ bus.ser_bit);
            state_d  = (chk_q && has_parity(mode_q)) ? PCHK : IDLE;
          end
        end
      end

      PCHK: begin
        // p_out_q already holds the parity computed for this frame
        if (bus.ser_abort) begin
          state_d = IDLE;
        end else if (bus.ser_valid) begin
          err_fire = (bus.ser_bit != p_out_q);
          state_d  = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q    <= 3'b000;
      len_q     <= MIN_LEN;
      chk_q     <= 1'b0;
      acc_q     <= 1'b0;
      cnt_q     <= 4'd0;
      p_out_q   <= 1'b0;
      p_valid_q <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      p_valid_q <= par_fire;
      par_err_q <= err_fire;
      if (par_fire) p_out_q <= par_val;

      if (cfg_latch) begin
        mode_q <= bus.mode;
        len_q  <= len_in;
        chk_q  <= bus.chk_en;
      end

      if (acc_clr) begin
        acc_q <= 1'b0;
        cnt_q <= 4'd0;
      end else if (acc_step) begin
        acc_q <= acc_q ^ bus.ser_bit;
        cnt_q <= cnt_q + 4'd1;
      end
    end
  end

  // Saturating error counter; a clear overrides a coincident increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (bus.clr_err) begin
      err_cnt_q <= '0;
    end else if (err_fire && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign bus.p_out     = p_out_q;
  assign bus.p_valid   = p_valid_q;
  assign bus.par_err   = par_err_q;
  assign bus.err_count = err_cnt_q;
  assign bus.busy      = (state_q != IDLE);

endmodule
